// File: rtl/alu_defs_pkg.sv
// Shared ALU definitions: function codes, issue opcodes and the issue-buffer entry record.
package alu_defs;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned FUNC_W   = 4;
  localparam int unsigned OP_W     = 6;
  localparam int unsigned IMM_W    = 16;
  localparam int unsigned SHAMT_W  = 5;

  localparam logic [FUNC_W-1:0] FN_ADD     = 4'd0;
  localparam logic [FUNC_W-1:0] FN_SUB     = 4'd1;
  localparam logic [FUNC_W-1:0] FN_AND     = 4'd2;
  localparam logic [FUNC_W-1:0] FN_OR      = 4'd3;
  localparam logic [FUNC_W-1:0] FN_XOR     = 4'd4;
  localparam logic [FUNC_W-1:0] FN_NOT     = 4'd5;
  localparam logic [FUNC_W-1:0] FN_SHL     = 4'd6;
  localparam logic [FUNC_W-1:0] FN_SRA     = 4'd7;
  localparam logic [FUNC_W-1:0] FN_SRL     = 4'd8;
  localparam logic [FUNC_W-1:0] FN_ILLEGAL = 4'hF;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'd0;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'd1;
  localparam logic [OP_W-1:0] OP_SUBI  = 6'd2;
  localparam logic [OP_W-1:0] OP_ANDI  = 6'd3;
  localparam logic [OP_W-1:0] OP_ORI   = 6'd4;
  localparam logic [OP_W-1:0] OP_XORI  = 6'd5;
  localparam logic [OP_W-1:0] OP_NOT   = 6'd6;
  localparam logic [OP_W-1:0] OP_SHLI  = 6'd7;
  localparam logic [OP_W-1:0] OP_SRAI  = 6'd8;
  localparam logic [OP_W-1:0] OP_SRLI  = 6'd9;

  // Highest R-type funct value that maps onto a real ALU function
  localparam logic [OP_W-1:0] FUNCT_MAX = 6'd8;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [FUNC_W-1:0] func;
    logic              illegal;
  } alu_entry_t;

endpackage

// File: rtl/alu_issue_if.sv
// Issue-stage handshake bundle: upstream instruction channel plus downstream ALU operation channel.
interface alu_issue_if;
  import alu_defs::*;

  logic               in_valid;
  logic               in_ready;
  logic [OP_W-1:0]    in_opcode;
  logic [OP_W-1:0]    in_funct;
  logic [DATA_W-1:0]  in_rs_val;
  logic [DATA_W-1:0]  in_rt_val;
  logic [IMM_W-1:0]   in_imm;
  logic [SHAMT_W-1:0] in_shamt;
  logic               out_valid;
  logic               out_ready;
  logic [DATA_W-1:0]  out_a;
  logic [DATA_W-1:0]  out_b;
  logic [FUNC_W-1:0]  out_func;
  logic               out_illegal;

  modport master (
    output in_valid, in_opcode, in_funct, in_rs_val, in_rt_val, in_imm, in_shamt, out_ready,
    input  in_ready, out_valid, out_a, out_b, out_func, out_illegal
  );

  modport slave (
    input  in_valid, in_opcode, in_funct, in_rs_val, in_rt_val, in_imm, in_shamt, out_ready,
    output in_ready, out_valid, out_a, out_b, out_func, out_illegal
  );

endinterface

// File: rtl/alu_issue_stage_decode.sv
// Combinational instruction decode into an ALU operand/function entry.
module alu_issue_decode
  import alu_defs::*;
#(
  parameter bit LOGIC_SEXT = 1'b0
) (
  input  logic [OP_W-1:0]    opcode,
  input  logic [OP_W-1:0]    funct,
  input  logic [DATA_W-1:0]  rs_val,
  input  logic [DATA_W-1:0]  rt_val,
  input  logic [IMM_W-1:0]   imm,
  input  logic [SHAMT_W-1:0] shamt,
  output alu_entry_t         entry
);

  logic [DATA_W-1:0] imm_sext;
  logic [DATA_W-1:0] imm_zext;
  logic [DATA_W-1:0] imm_logic;

  assign imm_sext  = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
  assign imm_zext  = {{(DATA_W-IMM_W){1'b0}}, imm};
  assign imm_logic = LOGIC_SEXT ? imm_sext : imm_zext;

  // Map opcode/funct to {a, b, func, illegal}; anything unrecognised falls through to the illegal tuple
  always_comb begin
    entry = '{a: '0, b: '0, func: FN_ILLEGAL, illegal: 1'b1};
    case (opcode)
      OP_RTYPE: begin
        if (funct <= FUNCT_MAX) begin
          entry = '{a: rs_val, b: rt_val, func: funct[FUNC_W-1:0], illegal: 1'b0};
        end
      end
      OP_ADDI: entry = '{a: rs_val, b: imm_sext,  func: FN_ADD, illegal: 1'b0};
      OP_SUBI: entry = '{a: rs_val, b: imm_sext,  func: FN_SUB, illegal: 1'b0};
      OP_ANDI: entry = '{a: rs_val, b: imm_logic, func: FN_AND, illegal: 1'b0};
      OP_ORI:  entry = '{a: rs_val, b: imm_logic, func: FN_OR,  illegal: 1'b0};
      OP_XORI: entry = '{a: rs_val, b: imm_logic, func: FN_XOR, illegal: 1'b0};
      OP_NOT:  entry = '{a: rs_val, b: '0,        func: FN_NOT, illegal: 1'b0};
      OP_SHLI: entry = '{a: rs_val, b: DATA_W'(shamt), func: FN_SHL, illegal: 1'b0};
      OP_SRAI: entry = '{a: rs_val, b: DATA_W'(shamt), func: FN_SRA, illegal: 1'b0};
      OP_SRLI: entry = '{a: rs_val, b: DATA_W'(shamt), func: FN_SRL, illegal: 1'b0};
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes accepted instructions into a small FIFO and presents the head entry to the ALU.
module alu_issue_stage
  import alu_defs::*;
#(
  parameter int unsigned DEPTH      = 2,
  parameter bit          LOGIC_SEXT = 1'b0
) (
  input logic        clk,
  input logic        rst,
  input logic        flush,
  alu_issue_if.slave bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  alu_entry_t       mem [DEPTH];
  alu_entry_t       dec_entry;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             ready_en;
  logic             push;
  logic             pop;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  alu_issue_decode #(.LOGIC_SEXT(LOGIC_SEXT)) u_decode (
    .opcode (bus.in_opcode),
    .funct  (bus.in_funct),
    .rs_val (bus.in_rs_val),
    .rt_val (bus.in_rt_val),
    .imm    (bus.in_imm),
    .shamt  (bus.in_shamt),
    .entry  (dec_entry)
  );

  // Handshake status comes only from registered state; ready_en keeps in_ready low throughout reset
  assign bus.in_ready  = ready_en && (count < CNT_W'(DEPTH));
  assign bus.out_valid = (count != '0);
  assign push          = bus.in_valid && bus.in_ready;
  assign pop           = bus.out_valid && bus.out_ready;

  // Head entry drives the ALU operands; storage is cleared in reset so these read zero then
  assign bus.out_a       = mem[rd_ptr].a;
  assign bus.out_b       = mem[rd_ptr].b;
  assign bus.out_func    = mem[rd_ptr].func;
  assign bus.out_illegal = mem[rd_ptr].illegal;

  // Release input acceptance on the first edge after reset deasserts
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ready_en <= 1'b0;
    else      ready_en <= 1'b1;
  end

  // Occupancy and pointers; flush discards everything including a same-cycle push
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= ptr_next(wr_ptr);
      if (pop)  rd_ptr <= ptr_next(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // Entry storage written with the decoded tuple at input transfer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push && !flush) begin
      mem[wr_ptr] <= dec_entry;
    end
  end

endmodule

// File: doc/alu_issue_stage.md
ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
REQ-001 The block SHALL have parameter DEPTH, default 2, meaning number of buffer entries (legal values 2 or 4).
REQ-002 The block SHALL have parameter LOGIC_SEXT, default 0, meaning that when it is 1, andi/ori/xori immediates are sign-extended instead of zero-extended.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset, as in REQ-004 and REQ-005.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous reset, active-low.
REQ-006 The block SHALL have port flush, input, 1 bit: synchronous clear of all buffered entries.
REQ-007 The block SHALL have port in_valid, input, 1 bit: an upstream instruction is present.
REQ-008 The block SHALL have port in_ready, output, 1 bit: the stage can accept an instruction this cycle.
REQ-009 The block SHALL have port in_opcode, input, 6 bits: instruction opcode.
REQ-010 The block SHALL have port in_funct, input, 6 bits: R-type function field.
REQ-011 The block SHALL have port in_rs_val, input, 32 bits: first register operand value.
REQ-012 The block SHALL have port in_rt_val, input, 32 bits: second register operand value.
REQ-013 The block SHALL have port in_imm, input, 16 bits: immediate field.
REQ-014 The block SHALL have port in_shamt, input, 5 bits: shift amount field.
REQ-015 The block SHALL have port out_valid, output, 1 bit: a decoded operation is presented to the ALU.
REQ-016 The block SHALL have port out_ready, input, 1 bit: the downstream consumer takes the operation this cycle.
REQ-017 The block SHALL have port out_a, output, 32 bits: ALU operand a.
REQ-018 The block SHALL have port out_b, output, 32 bits: ALU operand b.
REQ-019 The block SHALL have port out_func, output, 4 bits: ALU function code, with 0=add, 1=sub, 2=and, 3=or, 4=xor, 5=not, 6=shl, 7=sra, 8=srl.
REQ-020 The block SHALL have port out_illegal, output, 1 bit: the presented instruction did not decode.

Function
REQ-021 An input transfer SHALL occur when in_valid and in_ready are both 1; an output transfer SHALL occur when out_valid and out_ready are both 1.
REQ-022 in_ready SHALL equal (count < DEPTH), computed from registered count only, with no combinational path from out_ready.
REQ-023 Decode SHALL happen at input transfer, and the decoded tuple {a, b, func, illegal} SHALL be written into a FIFO entry.
REQ-024 Opcode 0 with funct 0..8 SHALL decode to a=rs, b=rt, func=funct[3:0].
REQ-025 Opcodes 1..5 (addi, subi, andi, ori, xori) SHALL decode to a=rs, b=imm, func=opcode-1; addi/subi sign-extend imm; andi/ori/xori extend imm per LOGIC_SEXT.
REQ-026 Opcode 6 (not) SHALL decode to a=rs, b=0, func=5.
REQ-027 Opcodes 7, 8, 9 (shli, srai, srli) SHALL decode to a=rs, b=zero-extended shamt, func=6, 7, 8 respectively.
REQ-028 Any other opcode, or opcode 0 with funct > 8, SHALL decode to a=0, b=0, func=4'hF, illegal=1; the entry SHALL still be enqueued and delivered in order.
REQ-029 Latency SHALL be one cycle: an entry accepted at edge N SHALL be visible on the out_* ports after edge N when the buffer was empty.
REQ-030 out_* SHALL be driven from the head entry only; out_valid SHALL equal (count != 0).
REQ-031 out_a, out_b, out_func and out_illegal SHALL be held stable while out_valid=1 and out_ready=0.
REQ-032 Simultaneous input and output transfer SHALL leave count unchanged and preserve order, including at count=1 and count=DEPTH-1.
REQ-033 At count=DEPTH, in_ready SHALL be 0, and in_valid SHALL be ignored.
REQ-034 Read and write pointers SHALL wrap modulo DEPTH.
REQ-035 flush=1 SHALL set count and both pointers to 0 at the next edge; a simultaneous input transfer SHALL be discarded, and flush SHALL take priority over everything except rst.

Reset
REQ-036 rst=0 SHALL immediately force count=0, both pointers=0, out_valid=0 and in_ready=0.
REQ-037 While rst=0, out_a, out_b and out_func SHALL be 0 and out_illegal SHALL be 0 (storage cleared).
REQ-038 in_ready SHALL go to 1 in the first cycle after rst deasserts.
REQ-039 Reset asserted mid-transfer SHALL lose all buffered entries without emitting a partial output.

Structure
REQ-040 The ALU function codes, opcode constants, the illegal code 4'hF and the entry record layout SHALL live in a shared package alu_defs, also used by the ALU.
REQ-041 Decode SHALL be one combinational sub-module, alu_issue_decode; the FIFO and handshake logic SHALL stay in alu_issue_stage.

Verification
REQ-042 The bench SHALL cover: opcode 1, rs=5, imm=16'hFFFF, out_ready=1 -> one cycle later out_a=5, out_b=32'hFFFFFFFF, out_func=0, out_illegal=0.
REQ-043 The bench SHALL cover: opcode 3, imm=16'h8000, once with LOGIC_SEXT=0 and once with LOGIC_SEXT=1 -> out_b=32'h00008000 and out_b=32'hFFFF8000 respectively, with out_func=2.
REQ-044 The bench SHALL cover: out_ready=0 with 3 instructions offered at DEPTH=2 -> in_ready=0 after 2 accepts; the third is held; on releasing out_ready, outputs appear in order 1, 2, 3.
REQ-045 The bench SHALL cover: opcode 0, funct=9 -> out_func=4'hF, out_illegal=1, out_a=0, out_b=0, and the following instruction is delivered normally.
REQ-046 The bench SHALL cover: count=1 with flush=1 and in_valid=1 in the same cycle -> next cycle out_valid=0, count=0, and the offered instruction is never output.
REQ-047 The bench SHALL cover: rst pulsed low while count=2 -> out_valid drops without waiting for a clock edge, and after release in_ready=1 and no stale output appears.
